// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage: default widths,
// the special instruction encodings and the fetch FSM state type.
package cpu_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;

    typedef logic [PC_W_DEF-1:0]    pc_t;
    typedef logic [INSTR_W_DEF-1:0] instr_t;

    // An all-ones word stops fetching; all-zeros is the harmless filler
    // held in the IF/ID register after reset.
    localparam instr_t HALT_INSTR = 32'hFFFF_FFFF;
    localparam instr_t NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline holding register: valid bit, pc and instruction.
// A flush clears the valid bit and wins over a load. Without either,
// the contents hold, which is how decode back-pressure is absorbed.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Next contents: flush drops the entry, load captures a new one, else hold.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    // Register update with synchronous reset to an empty NOP entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, RUN/HALT control FSM,
// accepted-transfer counter and the IF/ID holding register.
// The instruction memory is combinational and addressed directly by pc.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     fetchCount_q, fetchCount_d;

    logic loadEn;
    logic haltWord;
    logic acceptXfer;
    logic regLoad;
    logic regFlush;

    // A fetch happens in RUN when no redirect is pending and the IF/ID
    // register is empty or being drained by decode this cycle.
    always_comb begin
        haltWord   = (imem_data == INSTR_W'(HALT_INSTR));
        acceptXfer = if_valid && if_ready;
        loadEn     = (state_q == RUN) && !redirect_valid && (!if_valid || if_ready);
        regLoad    = loadEn && !haltWord;
        regFlush   = redirect_valid || (loadEn && haltWord);
    end

    // Next-state and pc logic; a redirect overrides everything and the
    // halt word parks pc on its own address without being delivered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = redirect_pc;
        end else if (loadEn) begin
            if (haltWord) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // Transfer counter: counts handshakes even when a redirect flushes the
    // register in the same cycle, and sticks at its maximum value.
    always_comb begin
        fetchCount_d = fetchCount_q;
        if (acceptXfer && (fetchCount_q != 16'hFFFF)) begin
            fetchCount_d = fetchCount_q + 16'd1;
        end
    end

    // State, pc and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= '0;
            fetchCount_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (regFlush),
        .load_i  (regLoad),
        .pc_i    (pc_q),
        .instr_i (imem_data),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic              halted;
    logic [15:0]       fetch_count;

    logic [31:0] mem [256];

    int compared   = 0;
    int mismatched = 0;

    // Reference model of the architecturally visible state.
    int          mPc;
    bit          mHalt;
    bit          mValid;
    int          mIfPc;
    logic [31:0] mIfInstr;
    int          mCount;
    bit          mFresh;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".imem_addr"}, 32'(imem_addr), 32'(mPc));
        checkValue({tag, ".if_valid"}, 32'(if_valid), 32'(mValid));
        checkValue({tag, ".halted"}, 32'(halted), 32'(mHalt));
        checkValue({tag, ".fetch_count"}, 32'(fetch_count), 32'(mCount));
        if (mValid || mFresh) begin
            checkValue({tag, ".if_pc"}, 32'(if_pc), 32'(mIfPc));
            checkValue({tag, ".if_instr"}, if_instr, mIfInstr);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rv, input int rpc, input bit rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = PC_W'(rpc);
        if_ready       = rdy;
    endtask

    // Advance one clock: the model computes the next state from the rules
    // using the inputs currently applied, then outputs are sampled 1ns later.
    task automatic step(input string tag, input bit doCheck);
        int          nPc      = mPc;
        bit          nHalt    = mHalt;
        bit          nValid   = mValid;
        int          nIfPc    = mIfPc;
        logic [31:0] nIfInstr = mIfInstr;
        int          nCount   = mCount;
        bit          nFresh   = mFresh;
        logic [31:0] word;
        if (rst) begin
            nPc = 0; nHalt = 0; nValid = 0; nIfPc = 0;
            nIfInstr = NOP_W; nCount = 0; nFresh = 1;
        end else begin
            if (mValid && if_ready && mCount < 65535) nCount = mCount + 1;
            if (redirect_valid) begin
                nPc    = int'(redirect_pc);
                nValid = 0;
                nHalt  = 0;
            end else if (!mHalt && (!mValid || if_ready)) begin
                word = mem[mPc];
                if (word == HALT_W) begin
                    nHalt  = 1;
                    nValid = 0;
                end else begin
                    nIfPc    = mPc;
                    nIfInstr = word;
                    nValid   = 1;
                    nPc      = (mPc + 1) % 256;
                    nFresh   = 0;
                end
            end
        end
        @(posedge clk);
        mPc = nPc; mHalt = nHalt; mValid = nValid; mIfPc = nIfPc;
        mIfInstr = nIfInstr; mCount = nCount; mFresh = nFresh;
        #1;
        if (doCheck) checkOutput(tag);
    endtask

    initial begin
        mPc = 0; mHalt = 0; mValid = 0; mIfPc = 0;
        mIfInstr = NOP_W; mCount = 0; mFresh = 1;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_W) mem[i] = 32'h1;
        end
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = HALT_W;

        // Straight-line run into the halt word.
        $display("[TB] program run to halt");
        applyStimulus(1, 0, 0, 0);
        step("reset", 1);
        checkValue("reset.if_valid", 32'(if_valid), 0);
        checkValue("reset.if_pc", 32'(if_pc), 0);
        checkValue("reset.if_instr", if_instr, NOP_W);
        checkValue("reset.fetch_count", 32'(fetch_count), 0);
        checkValue("reset.halted", 32'(halted), 0);
        applyStimulus(0, 0, 0, 1);
        step("run1", 1);
        checkValue("run1.instr", if_instr, 32'h11);
        step("run2", 1);
        checkValue("run2.instr", if_instr, 32'h22);
        step("run3", 1);
        checkValue("run3.instr", if_instr, 32'h33);
        step("run4", 1);
        checkValue("halt.halted", 32'(halted), 1);
        checkValue("halt.count", 32'(fetch_count), 3);
        checkValue("halt.pc", 32'(imem_addr), 3);
        checkValue("halt.valid", 32'(if_valid), 0);
        step("halt_hold1", 1);
        step("halt_hold2", 1);

        // Redirect out of HALT.
        applyStimulus(0, 1, 'h10, 1);
        step("unhalt", 1);
        checkValue("unhalt.halted", 32'(halted), 0);
        checkValue("unhalt.pc", 32'(imem_addr), 32'h10);
        applyStimulus(0, 0, 0, 1);
        step("unhalt_fetch", 1);
        checkValue("unhalt_fetch.if_pc", 32'(if_pc), 32'h10);

        // Back-pressure while holding 0x22.
        $display("[TB] decode stall");
        applyStimulus(1, 0, 0, 1);
        step("rst2", 1);
        applyStimulus(0, 0, 0, 1);
        step("s1", 1);
        step("s2", 1);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1);
            checkValue("stall.instr", if_instr, 32'h22);
            checkValue("stall.if_pc", 32'(if_pc), 1);
            checkValue("stall.pc", 32'(imem_addr), 2);
            checkValue("stall.count", 32'(fetch_count), 1);
        end
        applyStimulus(0, 0, 0, 1);
        step("release", 1);
        checkValue("release.instr", if_instr, 32'h33);

        // Redirect flushes an unaccepted instruction.
        applyStimulus(0, 0, 0, 0);
        step("hold33", 1);
        applyStimulus(0, 1, 'h80, 0);
        step("flush", 1);
        checkValue("flush.valid", 32'(if_valid), 0);
        checkValue("flush.pc", 32'(imem_addr), 32'h80);
        applyStimulus(0, 0, 0, 0);
        step("flush_fetch", 1);
        checkValue("flush_fetch.if_pc", 32'(if_pc), 32'h80);

        // Program counter wrap.
        applyStimulus(0, 1, 'hFF, 1);
        step("to_ff", 1);
        applyStimulus(0, 0, 0, 1);
        step("wrap1", 1);
        checkValue("wrap1.if_pc", 32'(if_pc), 32'hFF);
        step("wrap2", 1);
        checkValue("wrap2.if_pc", 32'(if_pc), 32'h00);

        // Reset mid-stream overrides a simultaneous redirect.
        applyStimulus(0, 0, 0, 0);
        step("pre_rst", 1);
        applyStimulus(1, 1, 'h40, 1);
        step("mid_rst", 1);
        checkValue("mid_rst.valid", 32'(if_valid), 0);
        checkValue("mid_rst.if_pc", 32'(if_pc), 0);
        checkValue("mid_rst.instr", if_instr, NOP_W);
        checkValue("mid_rst.pc", 32'(imem_addr), 0);
        checkValue("mid_rst.count", 32'(fetch_count), 0);
        applyStimulus(0, 0, 0, 1);
        step("restart", 1);
        checkValue("restart.if_pc", 32'(if_pc), 0);

        // Transfer and redirect in the same cycle: counted, then flushed.
        applyStimulus(0, 1, 'h20, 1);
        step("xfer_redir", 1);
        checkValue("xfer_redir.count", 32'(fetch_count), 1);
        checkValue("xfer_redir.valid", 32'(if_valid), 0);

        // Randomized traffic with sprinkled halt words.
        $display("[TB] random traffic");
        for (int i = 0; i < 12; i++) mem[$urandom_range(0, 255)] = HALT_W;
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            step("rand", 1);
        end

        // Counter saturation over a halt-free memory.
        $display("[TB] counter saturation");
        for (int i = 0; i < 256; i++) if (mem[i] == HALT_W) mem[i] = 32'h5;
        applyStimulus(1, 0, 0, 1);
        step("sat_rst", 1);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) begin
            step("sat", (i % 8192) == 0);
        end
        checkOutput("sat_end");
        checkValue("sat.count", 32'(fetch_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
